instruction_buffer: RTL and testbench

INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

---
 rtl/rv_pkg.sv | 10 +
 rtl/instr_buffer_mem.sv | 26 ++
 rtl/instruction_buffer.sv | 89 ++++++++
 tb/tb_instruction_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the fetch/decode front end.
package rv_pkg;

    // Canonical RV32 NOP: addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned PC_W_DEF   = 32;

endpackage

// File: rtl/instr_buffer_mem.sv
// Instruction buffer storage: one synchronous write port, one asynchronous read port.
module instr_buffer_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is not reset; validity is tracked by the controller's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_buffer.sv
// Fetch-to-decode instruction FIFO with flush, carrying the PC with each word.
module instruction_buffer
    import rv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [AW:0]       count
);

    localparam logic [AW:0]       DepthC = (AW + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] NopW   = DATA_W'(NOP);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic [DATA_W+PC_W-1:0] rdata;

    // Handshakes depend only on registered count, never on the opposite side.
    assign in_ready  = (count_q < DepthC);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Next pointer/count state; flush overrides any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    instr_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + PC_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata ({in_instr, in_pc}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Empty buffer presents a NOP at address zero.
    assign out_instr = out_valid ? rdata[DATA_W+PC_W-1:PC_W] : NopW;
    assign out_pc    = out_valid ? rdata[PC_W-1:0] : '0;

endmodule

// File: tb/tb_instruction_buffer.sv
// Self-checking bench for instruction_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instruction_buffer;
    import rv_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AW     = $clog2(DEPTH);

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [PC_W-1:0]   out_pc;
    logic [AW:0]       count;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } ent_t;

    ent_t model_q[$];
    int   checks = 0;
    int   errors = 0;

    instruction_buffer #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance past the edge, update the model.
    task automatic tick(input logic v, input logic [DATA_W-1:0] ins, input logic [PC_W-1:0] pc,
                        input logic rdy, input logic fl);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        do_push   = v && (model_q.size() < DEPTH);
        do_pop    = rdy && (model_q.size() > 0);
        e.instr   = ins;
        e.pc      = pc;
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
        #1;
        checks++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h13
            || out_pc !== 0) begin
            errors++;
            $display("FAIL reset_async: count=%0d ov=%b ir=%b instr=%h pc=%h, want 0 0 1 00000013 0",
                     count, out_valid, in_ready, out_instr, out_pc);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h13) begin
            errors++;
            $display("FAIL reset_release: count=%0d ov=%b ir=%b instr=%h, want 0 0 1 00000013",
                     count, out_valid, in_ready, out_instr);
        end
    endtask

    task automatic test_single_push();
        tick(1'b1, 32'h32, 32'h100, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h32 || out_pc !== 32'h100 || count !== 1) begin
            errors++;
            $display("FAIL single_push: ov=%b instr=%h pc=%h count=%0d, want 1 00000032 00000100 1",
                     out_valid, out_instr, out_pc, count);
        end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h13 || out_pc !== 0 || count !== 0) begin
            errors++;
            $display("FAIL single_drain: ov=%b instr=%h pc=%h count=%0d, want 0 00000013 0 0",
                     out_valid, out_instr, out_pc, count);
        end
    endtask

    task automatic test_fill_order();
        logic [DATA_W-1:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) tick(1'b1, vals[i], 32'h200 + 4 * i, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || count !== 4) begin
            errors++;
            $display("FAIL fill_full: ir=%b count=%0d, want 0 4", in_ready, count);
        end
        tick(1'b1, 32'h99, 32'h999, 1'b0, 1'b0);
        checks++;
        if (count !== 4 || out_instr !== 32'h11) begin
            errors++;
            $display("FAIL fill_overflow: count=%0d head=%h, want 4 00000011", count, out_instr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_instr !== vals[i] || out_pc !== 32'h200 + 4 * i) begin
                errors++;
                $display("FAIL fill_order[%0d]: instr=%h pc=%h, want %h %h", i, out_instr, out_pc,
                         vals[i], 32'h200 + 4 * i);
            end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (out_instr !== 32'h13 || out_valid !== 1'b0 || count !== 0) begin
            errors++;
            $display("FAIL fill_empty: instr=%h ov=%b count=%0d, want 00000013 0 0",
                     out_instr, out_valid, count);
        end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop: count=%0d ov=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_simultaneous();
        tick(1'b1, 32'hA1, 32'h300, 1'b0, 1'b0);
        tick(1'b1, 32'hA2, 32'h304, 1'b0, 1'b0);
        tick(1'b1, 32'h55, 32'h308, 1'b1, 1'b0);
        checks++;
        if (count !== 2 || out_instr !== 32'hA2) begin
            errors++;
            $display("FAIL simul_pushpop: count=%0d head=%h, want 2 000000a2", count, out_instr);
        end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_instr !== 32'h55 || out_pc !== 32'h308 || count !== 1) begin
            errors++;
            $display("FAIL simul_last: instr=%h pc=%h count=%0d, want 00000055 00000308 1",
                     out_instr, out_pc, count);
        end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h60 + i, 32'h400 + 4 * i, 1'b0, 1'b0);
        checks++;
        if (count !== 3) begin
            errors++;
            $display("FAIL flush_pre: count=%0d, want 3", count);
        end
        tick(1'b1, 32'h66, 32'h40C, 1'b1, 1'b1);
        checks++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h13) begin
            errors++;
            $display("FAIL flush: count=%0d ov=%b ir=%b instr=%h, want 0 0 1 00000013",
                     count, out_valid, in_ready, out_instr);
        end
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: count=%0d ov=%b, want 0 0", count, out_valid);
        end
        // Pointers must restart cleanly after a flush from a non-zero position.
        tick(1'b1, 32'h77, 32'h500, 1'b0, 1'b0);
        checks++;
        if (out_instr !== 32'h77 || out_pc !== 32'h500 || count !== 1) begin
            errors++;
            $display("FAIL flush_restart: instr=%h pc=%h count=%0d, want 00000077 00000500 1",
                     out_instr, out_pc, count);
        end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h80 + i, 32'h600 + 4 * i, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h13
            || out_pc !== 0) begin
            errors++;
            $display("FAIL async_reset: count=%0d ov=%b ir=%b instr=%h pc=%h, want 0 0 1 00000013 0",
                     count, out_valid, in_ready, out_instr, out_pc);
        end
        in_valid = 1'b1;
        in_instr = 32'hBAD;
        @(posedge clk);
        #1;
        checks++;
        if (count !== 0) begin
            errors++;
            $display("FAIL reset_no_push: count=%0d, want 0", count);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_q.delete();
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: count=%0d ov=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_instr;
        logic [PC_W-1:0]   exp_pc;
        for (int i = 0; i < 400; i++) begin
            exp_instr = (model_q.size() > 0) ? model_q[0].instr : NOP;
            exp_pc    = (model_q.size() > 0) ? model_q[0].pc : '0;
            checks++;
            if (count !== model_q.size() || out_valid !== (model_q.size() > 0)
                || in_ready !== (model_q.size() < DEPTH) || out_instr !== exp_instr
                || out_pc !== exp_pc) begin
                errors++;
                $display("FAIL random[%0d]: count=%0d ov=%b ir=%b instr=%h pc=%h, want %0d %b %b %h %h",
                         i, count, out_valid, in_ready, out_instr, out_pc, model_q.size(),
                         model_q.size() > 0, model_q.size() < DEPTH, exp_instr, exp_pc);
            end
            tick(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 19) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_order();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
